fifo_rd_ctrl: RTL

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/async_fifo_pkg.sv | 26 ++
 rtl/fifo_rd_ctrl_sync_w2r.sv | 25 ++
 rtl/fifo_rd_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for both halves of the asynchronous FIFO: default sizes and
// Gray-code helpers used by the read- and write-side pointer logic.
package async_fifo_pkg;

    localparam int DEF_DATALEN = 8;
    localparam int DEF_ADDRLEN = 4;
    localparam int DEF_DEPTH   = 8;

    // Helpers work on a wide vector so any pointer width can be zero-extended in.
    localparam int PTR_MAX = 32;
    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_sync_w2r.sv
// Two-flop synchroniser bringing the Gray-coded write pointer into the read clock domain.
module sync_w2r
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_ADDRLEN
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [WIDTH-1:0] wptr_gray,
    output logic [WIDTH-1:0] wq2
);

    logic [WIDTH-1:0] wq1;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wptr_gray;
            wq2 <= wq1;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: synchronises the write pointer,
// tracks the read pointer and empty flag, and presents RAM data through a one-word output register.
module fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int DATALEN = DEF_DATALEN,
    parameter int ADDRLEN = DEF_ADDRLEN,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic               rclk,
    input  logic               rrst,
    input  logic [ADDRLEN-1:0] wptr_gray,
    input  logic [DATALEN-1:0] rdata_mem,
    output logic [ADDRLEN-2:0] raddr,
    output logic [ADDRLEN-1:0] rptr_gray,
    output logic               rempty,
    output logic [DATALEN-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [ADDRLEN-1:0] rlevel
);

    if (DEPTH != 2 ** (ADDRLEN - 1)) begin : g_bad_depth
        $error("fifo_rd_ctrl: DEPTH must equal 2**(ADDRLEN-1)");
    end

    logic [ADDRLEN-1:0] wq2;
    logic [ADDRLEN-1:0] rbin;
    logic [ADDRLEN-1:0] rbin_next;
    logic               pop;

    sync_w2r #(.WIDTH(ADDRLEN)) u_sync_w2r (
        .rclk      (rclk),
        .rrst      (rrst),
        .wptr_gray (wptr_gray),
        .wq2       (wq2)
    );

    // Output handshake: a word transfers on any rclk edge where dout_valid && dout_ready;
    // dout is stable while dout_valid is high and dout_ready is low.
    assign pop       = !rempty && (!dout_valid || dout_ready);
    assign rbin_next = rbin + ADDRLEN'(pop);
    assign raddr     = rbin[ADDRLEN-2:0];
    assign rlevel    = ADDRLEN'(gray2bin(ptr_t'(wq2)) - ptr_t'(rbin));

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin       <= '0;
            rptr_gray  <= '0;
            rempty     <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            rbin      <= rbin_next;
            rptr_gray <= ADDRLEN'(bin2gray(ptr_t'(rbin_next)));
            // Compare against the post-pop pointer so a word just popped is not seen again.
            rempty    <= (bin2gray(ptr_t'(rbin_next)) == ptr_t'(wq2));
            if (pop) begin
                dout       <= rdata_mem;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule
